// File: rtl/capture_seq.sv
// rtl/capture_seq.sv - multi-stage triggered capture sequencer writing a ring buffer
module capture_seq #(
   parameter int SIZE    = 32,
   parameter int LEVELS  = 8,
   parameter int SADDR_W = 24,
   parameter int CNT_W   = 16
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     s_valid,
   input  logic [SIZE-1:0]                          s_data,
   input  logic                                     arm,
   input  logic                                     abort,
   input  logic [LEVELS*SIZE-1:0]                   trig_mask,
   input  logic [LEVELS*SIZE-1:0]                   trig_type,
   input  logic [LEVELS*SIZE-1:0]                   trig_level,
   input  logic [LEVELS*CNT_W-1:0]                  trig_count,
   input  logic [$clog2(LEVELS):0]                  num_levels,
   input  logic [SADDR_W-1:0]                       post_trigger_count,
   input  logic [SADDR_W-1:0]                       buffer_size,
   output logic                                     ready,
   output logic                                     armed,
   output logic                                     triggered,
   output logic                                     done,
   output logic [(LEVELS > 1 ? $clog2(LEVELS) : 1)-1:0] stage,
   output logic                                     wen,
   output logic [SADDR_W-1:0]                       waddr,
   output logic [SIZE-1:0]                          wdata,
   output logic [SADDR_W-1:0]                       trigger_pos
);

   localparam int SW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   hits;
   logic [SADDR_W-1:0] wptr;       // address the next accepted sample goes to
   logic [SADDR_W-1:0] pcnt;       // samples written since the trigger
   logic [SIZE-1:0]    hist;       // previous accepted sample, for edge bits
   logic               hist_valid;

   logic [SIZE-1:0]    cur_mask, cur_type, cur_level, bit_hit;
   logic [CNT_W-1:0]   cur_count, need;
   logic [CNT_W:0]     hits_inc;
   logic               stage_match, hit_done, small_ring, post_last;
   logic [SW-1:0]      last_stage;
   logic [SADDR_W-1:0] next_ptr, post_target;

   assign ready     = (state == S_IDLE);
   assign armed     = (state == S_ARMED);
   assign triggered = (state == S_POST) || (state == S_DONE);
   assign done      = (state == S_DONE);

   // current-stage match, hit threshold, ring pointer advance and post-trigger target
   always_comb begin
      cur_mask  = trig_mask[stage*SIZE +: SIZE];
      cur_type  = trig_type[stage*SIZE +: SIZE];
      cur_level = trig_level[stage*SIZE +: SIZE];
      cur_count = trig_count[stage*CNT_W +: CNT_W];
      // edge bits need a history sample whose bit differed from the level
      bit_hit     = (s_data ~^ cur_level) &
                    (~cur_type | ({SIZE{hist_valid}} & (hist ^ cur_level)));
      stage_match = &(~cur_mask | bit_hit);
      need        = (cur_count == '0) ? CNT_W'(1) : cur_count;
      hits_inc    = {1'b0, hits} + 1'b1;
      hit_done    = (hits_inc >= {1'b0, need});
      if (num_levels == '0)
         last_stage = '0;
      else if (int'(num_levels) > LEVELS)
         last_stage = SW'(LEVELS - 1);
      else
         last_stage = SW'(num_levels - 1'b1);
      small_ring = (buffer_size <= SADDR_W'(1));
      if (small_ring || (wptr >= buffer_size - 1'b1))
         next_ptr = '0;
      else
         next_ptr = wptr + 1'b1;
      // the ring can never hold more than buffer_size-1 samples after the trigger
      if (small_ring)
         post_target = '0;
      else if (post_trigger_count < buffer_size - 1'b1)
         post_target = post_trigger_count;
      else
         post_target = buffer_size - 1'b1;
      post_last = (({1'b0, pcnt} + 1'b1) >= {1'b0, post_target});
   end

   // capture state machine, trigger stage walk and buffer write port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         stage       <= '0;
         hits        <= '0;
         wptr        <= '0;
         pcnt        <= '0;
         hist        <= '0;
         hist_valid  <= 1'b0;
         wen         <= 1'b0;
         waddr       <= '0;
         wdata       <= '0;
         trigger_pos <= '0;
      end else begin
         wen <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  state      <= S_ARMED;
                  stage      <= '0;
                  hits       <= '0;
                  wptr       <= '0;
                  waddr      <= '0;
                  pcnt       <= '0;
                  hist_valid <= 1'b0;
               end
            end
            default: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (s_valid) begin
                  wen        <= 1'b1;
                  wdata      <= s_data;
                  waddr      <= wptr;
                  wptr       <= next_ptr;
                  hist       <= s_data;
                  hist_valid <= 1'b1;
                  if (state == S_ARMED) begin
                     if (stage_match) begin
                        if (hit_done) begin
                           hits <= '0;
                           if (stage == last_stage) begin
                              trigger_pos <= wptr;
                              state       <= (post_target == '0) ? S_DONE : S_POST;
                           end else begin
                              stage <= stage + 1'b1;
                           end
                        end else begin
                           hits <= hits_inc[CNT_W-1:0];
                        end
                     end
                  end else begin
                     pcnt <= pcnt + 1'b1;
                     if (post_last)
                        state <= S_DONE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_capture_seq.sv
// tb/tb_capture_seq.sv - scoreboard bench for capture_seq against a sample-level reference model
module tb_capture_seq;

   localparam int SIZE = 32, LEVELS = 8, SADDR_W = 24, CNT_W = 16;

   logic                     clk = 0;
   logic                     reset = 0;
   logic                     s_valid = 0, arm = 0, abort = 0;
   logic [SIZE-1:0]          s_data = '0;
   logic [LEVELS*SIZE-1:0]   trig_mask = '0, trig_type = '0, trig_level = '0;
   logic [LEVELS*CNT_W-1:0]  trig_count = '0;
   logic [3:0]               num_levels = 4'd1;
   logic [SADDR_W-1:0]       post_trigger_count = '0, buffer_size = '0;
   logic                     ready, armed, triggered, done, wen;
   logic [2:0]               stage;
   logic [SADDR_W-1:0]       waddr, trigger_pos;
   logic [SIZE-1:0]          wdata;

   capture_seq #(.SIZE(SIZE), .LEVELS(LEVELS), .SADDR_W(SADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .arm(arm), .abort(abort),
      .trig_mask(trig_mask), .trig_type(trig_type), .trig_level(trig_level),
      .trig_count(trig_count), .num_levels(num_levels),
      .post_trigger_count(post_trigger_count), .buffer_size(buffer_size),
      .ready(ready), .armed(armed), .triggered(triggered), .done(done), .stage(stage),
      .wen(wen), .waddr(waddr), .wdata(wdata), .trigger_pos(trigger_pos)
   );

   always #5 clk = ~clk;

   typedef struct {int addr; logic [31:0] data;} wr_t;
   wr_t exp_q[$];

   int checks = 0, errors = 0;
   bit mon_on = 0;

   // reference model: 0 idle, 1 armed, 2 post, 3 done
   int m_state = 0, m_stage = 0, m_hits = 0, m_wptr = 0, m_pcnt = 0, m_tpos = 0;
   logic [31:0] m_prev = '0;
   bit m_hv = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int eff_levels();
      int n = int'(num_levels);
      if (n == 0) return 1;
      if (n > LEVELS) return LEVELS;
      return n;
   endfunction

   function automatic int post_target();
      int bs = int'(buffer_size), p = int'(post_trigger_count);
      if (bs <= 1) return 0;
      return (p < bs - 1) ? p : bs - 1;
   endfunction

   function automatic bit m_match(input int k, input logic [31:0] d);
      logic [31:0] mk = trig_mask[k*SIZE +: SIZE];
      logic [31:0] ty = trig_type[k*SIZE +: SIZE];
      logic [31:0] lv = trig_level[k*SIZE +: SIZE];
      for (int b = 0; b < SIZE; b++) begin
         if (mk[b]) begin
            if (d[b] != lv[b]) return 0;
            if (ty[b] && (!m_hv || m_prev[b] == lv[b])) return 0;
         end
      end
      return 1;
   endfunction

   task automatic model_reset();
      m_state = 0; m_stage = 0; m_hits = 0; m_wptr = 0; m_pcnt = 0; m_tpos = 0;
      m_prev = '0; m_hv = 0;
      exp_q.delete();
   endtask

   task automatic model_edge(input bit v, input logic [31:0] d, input bit a, input bit ab);
      int addr, need, bs;
      if (m_state == 0 || m_state == 3) begin
         if (a) begin
            m_state = 1; m_stage = 0; m_hits = 0; m_wptr = 0; m_pcnt = 0; m_hv = 0;
         end
      end else if (ab) begin
         m_state = 0;
      end else if (v) begin
         addr = m_wptr;
         exp_q.push_back('{addr, d});
         bs = int'(buffer_size);
         m_wptr = (bs <= 1) ? 0 : (m_wptr + 1) % bs;
         if (m_state == 1) begin
            if (m_match(m_stage, d)) begin
               need = int'(trig_count[m_stage*CNT_W +: CNT_W]);
               if (need == 0) need = 1;
               m_hits++;
               if (m_hits >= need) begin
                  m_hits = 0;
                  if (m_stage == eff_levels() - 1) begin
                     m_tpos = addr;
                     m_state = (post_target() == 0) ? 3 : 2;
                  end else begin
                     m_stage++;
                  end
               end
            end
         end else begin
            m_pcnt++;
            if (m_pcnt >= post_target()) m_state = 3;
         end
         m_prev = d; m_hv = 1;
      end
   endtask

   task automatic cycle(input bit v, input logic [31:0] d, input bit a, input bit ab);
      s_valid = v; s_data = d; arm = a; abort = ab;
      @(posedge clk);
      model_edge(v, d, a, ab);
      #1;
      s_valid = 0; arm = 0; abort = 0;
   endtask

   task automatic clear_cfg();
      trig_mask = '0; trig_type = '0; trig_level = '0; trig_count = '0;
   endtask

   task automatic set_stage(input int k, input logic [31:0] mk, input logic [31:0] ty,
                            input logic [31:0] lv, input logic [15:0] cnt);
      trig_mask[k*SIZE +: SIZE] = mk;
      trig_type[k*SIZE +: SIZE] = ty;
      trig_level[k*SIZE +: SIZE] = lv;
      trig_count[k*CNT_W +: CNT_W] = cnt;
   endtask

   task automatic to_idle();
      if (m_state == 1 || m_state == 2) cycle(0, 0, 0, 1);
   endtask

   // monitor: flags every cycle, and each write popped against the scoreboard
   always @(negedge clk) begin
      wr_t e;
      if (mon_on) begin
         check("flags", {ready, armed, triggered, done},
               {m_state == 0, m_state == 1, m_state >= 2, m_state == 3});
         check("stage", stage, m_stage);
         check("trigger_pos", trigger_pos, m_tpos);
         if (wen) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("waddr", waddr, e.addr);
               check("wdata", wdata, e.data);
            end
         end
         check("missing_write", exp_q.size(), 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready, 1);
      check("rst_flags", {armed, triggered, done, wen}, 0);
      check("rst_outs", {stage, waddr, wdata, trigger_pos}, 0);
      reset = 1;
      mon_on = 1;

      // single level trigger on bit0, post 4
      clear_cfg(); set_stage(0, 1, 0, 1, 1);
      num_levels = 1; post_trigger_count = 4; buffer_size = 128;
      cycle(0, 0, 1, 0);
      cycle(1, 0, 0, 0); cycle(1, 0, 0, 0); cycle(1, 1, 0, 0);
      check("r31_trig", triggered, 1);
      check("r31_tpos", trigger_pos, 2);
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
      check("r31_done", done, 1);
      check("r31_last_addr", waddr, 6);

      // three stages: 0xA, two bit0 rising edges, 0xF
      clear_cfg();
      set_stage(0, 32'hF, 0, 32'hA, 1);
      set_stage(1, 32'h1, 32'h1, 32'h1, 2);
      set_stage(2, 32'hF, 0, 32'hF, 1);
      num_levels = 3; post_trigger_count = 2; buffer_size = 16;
      cycle(0, 0, 1, 0);
      cycle(1, 32'hA, 0, 0);
      check("r32_stage1", stage, 1);
      cycle(1, 1, 0, 0); cycle(1, 0, 0, 0);
      check("r32_one_edge", stage, 1);
      cycle(1, 1, 0, 0);
      check("r32_stage2", stage, 2);
      cycle(1, 32'hF, 0, 0);
      check("r32_trig", {triggered, trigger_pos}, {1'b1, 24'd4});
      cycle(1, 3, 0, 0); cycle(1, 4, 0, 0);
      check("r32_done", done, 1);

      // wrap: buffer 8, trigger on sample 10
      clear_cfg(); set_stage(0, 1, 0, 1, 1);
      num_levels = 1; post_trigger_count = 20; buffer_size = 8;
      cycle(0, 0, 1, 0);
      for (int i = 0; i < 10; i++) cycle(1, 32'h100 + i * 2, 0, 0);
      cycle(1, 1, 0, 0);
      check("r33_tpos", trigger_pos, 2);
      for (int i = 0; i < 6; i++) cycle(1, i * 2, 0, 0);
      check("r33_not_done", done, 0);
      cycle(1, 0, 0, 0);
      check("r33_done", {done, waddr}, {1'b1, 24'd1});

      // abort with arm in post, then fresh arm
      post_trigger_count = 5; buffer_size = 32;
      cycle(0, 0, 1, 0); cycle(1, 1, 0, 0);
      check("r34_post", triggered, 1);
      cycle(0, 0, 1, 1);
      check("r34_idle", {ready, done}, 2'b10);
      cycle(0, 0, 1, 0); cycle(1, 32'h55, 0, 0);
      check("r34_restart", {wen, waddr}, {1'b1, 24'd0});
      to_idle();

      // edge stage with no history on first sample, post 0
      clear_cfg(); set_stage(0, 1, 1, 1, 1);
      num_levels = 1; post_trigger_count = 0; buffer_size = 16;
      cycle(0, 0, 1, 0); cycle(1, 1, 0, 0);
      check("r35_first_no_match", armed, 1);
      cycle(1, 0, 0, 0); cycle(1, 1, 0, 0);
      check("r35_edge_done", {done, trigger_pos}, {1'b1, 24'd2});

      // randomized runs
      for (int run = 0; run < 40; run++) begin
         to_idle();
         clear_cfg();
         for (int k = 0; k < LEVELS; k++) begin
            logic [31:0] mk;
            mk = $urandom_range(0, 15);
            set_stage(k, mk, mk & $urandom_range(0, 15) & {31'd0, ($urandom_range(0, 2) == 0)},
                      $urandom_range(0, 15), 16'($urandom_range(0, 3)));
         end
         num_levels = 4'($urandom_range(0, 10));
         post_trigger_count = 24'($urandom_range(0, 15));
         buffer_size = 24'($urandom_range(0, 12));
         cycle(0, 0, 1, 0);
         for (int i = 0; i < 60; i++) begin
            d = $urandom & 32'h8000_000F;
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 30) == 0,
                  $urandom_range(0, 60) == 0);
         end
      end

      // asynchronous reset mid-post
      to_idle();
      clear_cfg(); set_stage(0, 1, 0, 1, 1);
      num_levels = 1; post_trigger_count = 20; buffer_size = 64;
      cycle(0, 0, 1, 0); cycle(1, 0, 0, 0); cycle(1, 1, 0, 0); cycle(1, 32'h77, 0, 0);
      check("r36_in_post", triggered, 1);
      @(posedge clk);
      #3;
      reset = 0;
      model_reset();
      #1;
      check("r36_ready", ready, 1);
      check("r36_flags", {armed, triggered, done, wen}, 0);
      check("r36_outs", {stage, waddr, wdata, trigger_pos}, 0);
      @(posedge clk);
      #1;
      reset = 1;
      cycle(0, 0, 0, 0);
      check("r36_release_no_write", wen, 0);
      cycle(0, 0, 0, 0);
      check("end_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/capture_seq.md
CAPTURE_SEQ -- requirements
Module: capture_seq

Interface
REQ-001 Parameters SHALL be: SIZE, 32, sample width; LEVELS, 8, trigger stages (1..16); SADDR_W, 24, buffer address width; CNT_W, 16, per-stage occurrence counter width.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 reset  in  1  asynchronous, active-low.
REQ-004 s_valid  in  1  sample strobe; s_data  in  SIZE  sample, valid when s_valid=1.
REQ-005 arm  in  1  start capture; abort  in  1  cancel capture.
REQ-006 trig_mask, trig_type, trig_level  in  LEVELS*SIZE each  per-stage config, stage k at bits [k*SIZE +: SIZE].
REQ-007 trig_count  in  LEVELS*CNT_W  required matches per stage; num_levels  in  $clog2(LEVELS)+1  active stages.
REQ-008 post_trigger_count, buffer_size  in  SADDR_W each  samples after trigger; ring length.
REQ-009 ready, armed, triggered, done  out  1 each  state flags.
REQ-010 stage  out  $clog2(LEVELS) (min 1)  current stage index.
REQ-011 wen  out  1; waddr  out  SADDR_W; wdata  out  SIZE  buffer write port.
REQ-012 trigger_pos  out  SADDR_W  buffer address of the triggering sample.

Function
REQ-013 States SHALL be IDLE, ARMED, POST, DONE; ready=IDLE, armed=ARMED, triggered=POST|DONE, done=DONE.
REQ-014 IDLE/DONE + arm=1 -> ARMED next cycle; stage, hit counter, waddr, post counter, edge-history valid cleared; trigger_pos held until the trigger.
REQ-015 arm in ARMED or POST SHALL be ignored.
REQ-016 abort=1 in ARMED or POST -> IDLE next cycle, done not set; abort wins over simultaneous arm; abort in IDLE/DONE ignored.
REQ-017 Per bit b of stage k: type=0 -> match when s_data[b]==level[b]; type=1 -> match when s_data[b]==level[b] and previous accepted sample bit != level[b]; bit ignored when mask[b]=0.
REQ-018 Stage matches when all masked bits match; mask all-zero -> every accepted sample matches.
REQ-019 Edge bits SHALL NOT match on the first accepted sample after arm (no history).
REQ-020 In ARMED each s_valid=1 cycle: if stage matches, hit counter +1; on reaching max(trig_count[k],1) stage advances, hit counter clears; non-matches do not clear hits.
REQ-021 num_levels=0 treated as 1; values >LEVELS treated as LEVELS.
REQ-022 Completing stage num_levels-1 -> POST; trigger_pos = waddr assigned to that same sample.
REQ-023 In ARMED and POST every s_valid=1 sample SHALL be written: wen=1, wdata=s_data, waddr = ring address, registered, exactly 1 cycle after s_valid.
REQ-024 waddr SHALL increment per written sample, wrapping buffer_size-1 -> 0; buffer_size 0 or 1 -> waddr stays 0.
REQ-025 POST SHALL write min(post_trigger_count, buffer_size-1) further samples, then -> DONE the cycle after the last write is issued; count 0 -> DONE the cycle after the trigger.
REQ-026 No writes in IDLE or DONE; wen=0 otherwise.
REQ-027 s_valid=0 cycles SHALL not change stage, counters, history or waddr.
REQ-028 Config inputs are static while armed; changes mid-capture take effect at the next sample, no protection.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE: ready=1; armed, triggered, done, wen=0; stage, waddr, wdata, trigger_pos=0; all counters and history cleared.
REQ-030 Reset release mid-operation returns to IDLE; no write issued in the cycle of release.

Verification
REQ-031 num_levels=1, mask=0x1, type=0, level=0x1, count=1, post=4, buffer=128; arm; samples 0,0,1,0.. -> trigger_pos=2, writes at addr 0..6, done after addr-6 write.
REQ-032 3 stages: level 0xA, rising edge bit0, level 0xF, counts 1,2,1 -> stage steps 0->1->2 only after two bit0 rising edges; triggered on the first 0xF after.
REQ-033 buffer=8, post=20, trigger on sample 10 -> trigger_pos=2, 7 post writes, waddr wraps 7->0, done.
REQ-034 Abort with arm in POST -> IDLE next cycle, done=0, ready=1; fresh arm restarts waddr=0.
REQ-035 Edge stage on bit0, first sample after arm =1 -> no match; subsequent 0->1 -> match.
REQ-036 reset=0 asserted mid-POST without clock edge -> all outputs at reset values immediately.
